crc8_framer: RTL

- Streaming CRC-8 generator/framer.
- Accepts packets as a byte stream with a last-byte marker and forwards them unchanged, then appends one CRC-8 byte as the new last byte.
- Sequences the existing `crc8` core: drives its data/valid inputs from accepted bytes and issues its synchronous clear between packets.
- Sits between a byte-stream source (e.g. UART/SPI TX packetiser) and the physical-layer serialiser.

---
 rtl/crc8_pkg.sv | 25 ++
 rtl/crc8.sv | 32 +++
 rtl/crc8_framer.sv | 111 +++++++++++
 3 files changed

// File: rtl/crc8_pkg.sv
// Shared types and constants for the CRC-8 framer and its core.
// crc8_next() advances an MSB-first CRC-8 register by one byte.
package crc8_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    DATA  = 2'd1,
    CRC   = 2'd2
  } state_e;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam int         STATS_W           = 16;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                           input logic [7:0] data,
                                           input logic [7:0] poly);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8.sv
// Byte-wide CRC-8 core: init 0, no reflection, no final XOR.
// crc_o reflects every byte presented with data_valid_i on the following cycle; rst_i clears synchronously.
module crc8
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLYNOMIAL = CRC8_POLY_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  assign crc_d = crc8_next(crc_q, data_i, POLYNOMIAL);
  assign crc_o = crc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= 8'h00;
    end else if (rst_i) begin
      crc_q <= 8'h00;
    end else if (data_valid_i) begin
      crc_q <= crc_d;
    end
  end

endmodule

// File: rtl/crc8_framer.sv
// Streaming CRC-8 framer: forwards payload bytes one cycle later, then appends the CRC as the last byte.
// Upstream stalls while the output register is full and for the CRC and CLEAR cycles; optional CRC8_FRAMER_STATS_EN adds pkt_count_o.
module crc8_framer
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLYNOMIAL = CRC8_POLY_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [7:0]         s_data_i,
  input  logic               s_valid_i,
  input  logic               s_last_i,
  output logic               s_ready_o,
  output logic [7:0]         m_data_o,
  output logic               m_valid_o,
  output logic               m_last_o,
  input  logic               m_ready_i,
  output logic               busy_o
`ifdef CRC8_FRAMER_STATS_EN
  ,
  output logic [STATS_W-1:0] pkt_count_o
`endif
);

  state_e     state_q;
  logic [7:0] m_data_q;
  logic       m_valid_q;
  logic       m_last_q;
  logic       busy_q;
  logic [7:0] crc;
  logic       out_free;
  logic       accept;
  logic       crc_hs;

  assign out_free  = !m_valid_q || m_ready_i;
  assign s_ready_o = (state_q == DATA) && out_free;
  assign accept    = s_valid_i && s_ready_o;
  assign crc_hs    = m_valid_q && m_last_q && m_ready_i;

  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign m_last_o  = m_last_q;
  assign busy_o    = busy_q;

  crc8 #(
    .POLYNOMIAL(POLYNOMIAL)
  ) u_crc8 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rst_i       (state_q == CLEAR),
    .data_i      (s_data_i),
    .data_valid_i(accept),
    .crc_o       (crc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= CLEAR;
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (m_valid_q && m_ready_i) begin
        m_valid_q <= 1'b0;
      end
      // A new packet's first byte may be accepted on the same cycle the old CRC drains.
      if (crc_hs) begin
        busy_q <= 1'b0;
      end
      unique case (state_q)
        CLEAR: state_q <= DATA;
        DATA: begin
          if (accept) begin
            m_data_q  <= s_data_i;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            if (s_last_i) begin
              state_q <= CRC;
            end
          end
        end
        CRC: begin
          if (out_free) begin
            m_data_q  <= crc;
            m_last_q  <= 1'b1;
            m_valid_q <= 1'b1;
            state_q   <= CLEAR;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

`ifdef CRC8_FRAMER_STATS_EN
  logic [STATS_W-1:0] pkt_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_cnt_q <= '0;
    end else if (crc_hs) begin
      pkt_cnt_q <= pkt_cnt_q + 1'b1;
    end
  end

  assign pkt_count_o = pkt_cnt_q;
`endif

endmodule
